// File: rtl/seg_pkg.sv
// Shared constants and FSM state encoding for the multiplexed seven-segment driver.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam int         DIGIT_W   = 8;

    typedef logic [1:0] seg_state_t;

    localparam seg_state_t ST_IDLE  = 2'd0;
    localparam seg_state_t ST_BLANK = 2'd1;
    localparam seg_state_t ST_SHOW  = 2'd2;

endpackage

// File: rtl/seg_strobe_timer.sv
// Slot timer: counts 0..i_limit and pulses o_tick on the terminal cycle while running.
module seg_strobe_timer
    import seg_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_limit,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;

    // >= so that lowering the limit mid-slot closes the slot on the next cycle
    assign o_tick = i_run && (r_cnt >= i_limit);
    assign o_cnt  = r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_run || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_mux_driver.sv
// Multiplexed seven-segment scanner with dead-time blanking and PWM brightness.
// Optional per-digit blinking is built only when SEG_BLINK_EN is defined.
module seg_mux_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CNT_W        = 32,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_SCANS  = 256
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic                          enable,
    input  logic [CNT_W-1:0]              cyclesPerStrobe,
    input  logic [3:0]                    brightness,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]         blinkMask,
    output logic [6:0]                    SegOut,
    output logic                          DpOut,
    output logic [NUM_DIGITS-1:0]         AnOut,
    output logic                          scanDone
);

    // state | meaning
    // IDLE  | scanning disabled, counters and index held at 0, outputs dark
    // BLANK | dead time at the start of a slot, outputs dark
    // SHOW  | captured digit driven, anode gated by PWM

    localparam int IDX_W = $clog2(NUM_DIGITS);

    seg_state_t             r_state;
    seg_state_t             w_state_next;
    seg_state_t             w_slot_state;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       w_idx_next;
    logic [IDX_W-1:0]       w_slot_idx;
    logic [DIGIT_W-1:0]     r_byte;
    logic [DIGIT_W-1:0]     w_byte;
    logic [3:0]             r_pwm;
    logic [6:0]             r_seg;
    logic                   r_dp;
    logic [NUM_DIGITS-1:0]  r_an;
    logic [NUM_DIGITS-1:0]  w_an_next;
    logic                   r_scan_done;
    logic [CNT_W-1:0]       w_cnt;
    logic                   w_tick;
    logic                   w_run;
    logic                   w_last;
    logic                   w_wrap;
    logic                   w_slot_start;
    logic                   w_show;
    logic                   w_blink_dark;

    assign w_run = enable && (r_state != ST_IDLE);

    seg_strobe_timer #(
        .CNT_W (CNT_W)
    ) u_strobe_timer (
        .i_clk   (CLK),
        .i_rst_n (RSTN),
        .i_run   (w_run),
        .i_limit (cyclesPerStrobe),
        .o_cnt   (w_cnt),
        .o_tick  (w_tick)
    );

    assign w_last       = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_wrap       = w_tick && w_last;
    assign w_idx_next   = w_last ? '0 : r_idx + 1'b1;
    assign w_slot_state = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
    assign w_slot_start = enable && ((r_state == ST_IDLE) || w_tick);
    assign w_slot_idx   = (r_state == ST_IDLE) ? '0 : w_idx_next;
    assign w_byte       = digits[int'(w_slot_idx)*DIGIT_W +: DIGIT_W];
    assign w_show       = enable && (r_state == ST_SHOW);

    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_next = w_slot_state;
                ST_BLANK: begin
                    if (w_tick) begin
                        w_state_next = w_slot_state;
                    end else if (({1'b0, w_cnt} + 1'b1) == (CNT_W+1)'(BLANK_CYCLES)) begin
                        w_state_next = ST_SHOW;
                    end
                end
                ST_SHOW:  if (w_tick) w_state_next = w_slot_state;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_byte  <= {1'b1, SEG_BLANK};
            r_pwm   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pwm   <= r_pwm + 1'b1;
            if (!enable) begin
                r_idx <= '0;
            end else if (w_tick) begin
                r_idx <= w_idx_next;
            end
            if (w_slot_start) begin
                r_byte <= w_byte;
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int SC_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    logic [SC_W-1:0] r_scans;
    logic            r_phase;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_scans <= '0;
            r_phase <= 1'b0;
        end else if (!enable) begin
            r_scans <= '0;
            r_phase <= 1'b0;
        end else if (w_wrap) begin
            if (r_scans == SC_W'(BLINK_SCANS - 1)) begin
                r_scans <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_scans <= r_scans + 1'b1;
            end
        end
    end

    assign w_blink_dark = r_phase && blinkMask[r_idx];
`else
    // mask and scan count are referenced only to keep the port; this folds to zero
    assign w_blink_dark = 1'b0 && (|blinkMask) && (BLINK_SCANS > 0);
`endif

    always_comb begin
        w_an_next = '1;
        if (w_show && (r_pwm < brightness) && !w_blink_dark) begin
            w_an_next[r_idx] = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_seg       <= SEG_BLANK;
            r_dp        <= 1'b1;
            r_an        <= '1;
            r_scan_done <= 1'b0;
        end else begin
            r_seg       <= w_show ? r_byte[6:0] : SEG_BLANK;
            r_dp        <= w_show ? r_byte[7] : 1'b1;
            r_an        <= w_an_next;
            r_scan_done <= w_wrap;
        end
    end

    assign SegOut   = r_seg;
    assign DpOut    = r_dp;
    assign AnOut    = r_an;
    assign scanDone = r_scan_done;

endmodule
